// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands each
// instruction downstream with valid/ready. Optional halt support via FETCH_HALT_EN.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 12,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [1:0]          BR_OPCODE   = 2'd2
`ifdef FETCH_HALT_EN
    ,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = {INSTR_WIDTH{1'b1}}
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PC_WIDTH-1:0]    pc_out,
    input  logic                   branch_res,
    input  logic [PC_WIDTH-1:0]    new_pc,
    output logic [15:0]            br_taken_cnt,
    output logic                   halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        BR_WAIT
`ifdef FETCH_HALT_EN
        ,
        HALT
`endif
    } state_t;

    state_t               state;
    logic [PC_WIDTH-1:0]  pc;

    assign imem_addr = pc;

`ifndef FETCH_HALT_EN
    assign halted = 1'b0;
`endif

    // imem_req is raised on every entry into FETCH so it is valid in the FETCH cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            instr_out    <= '0;
            instr_valid  <= 1'b0;
            pc_out       <= RESET_PC;
            br_taken_cnt <= '0;
`ifdef FETCH_HALT_EN
            halted       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_valid) begin
                        instr_out   <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + PC_WIDTH'(1);
`ifdef FETCH_HALT_EN
                        if (instr_out == HALT_INSTR) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else
`endif
                        if (instr_out[1:0] == BR_OPCODE) begin
                            state <= BR_WAIT;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                BR_WAIT: begin
                    // The branch stage's registered result is only trusted in this bubble.
                    if (branch_res) begin
                        pc <= new_pc;
                        if (br_taken_cnt != 16'hFFFF) begin
                            br_taken_cnt <= br_taken_cnt + 16'd1;
                        end
                    end
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a PC-walk reference model predicts the
// issued instruction stream; a monitor compares every presented instruction against it.
module tb_fetch_unit;

    typedef struct {
        logic [11:0] pc;
        logic [15:0] instr;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [11:0] pc_out;
    logic        branch_res = 1'b0;
    logic [11:0] new_pc = '0;
    logic [15:0] br_taken_cnt;
    logic        halted;

    logic [15:0] mem [0:4095];
    logic        br_take [0:1023];
    logic [11:0] br_tgt [0:1023];
    exp_t        sb [$];

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    logic strict = 1'b1;

    int   hs_count = 0;
    int   br_seen = 0;
    int   last_cycle = 0;
    logic last_br = 1'b0;
    logic gap_valid = 1'b0;

    int br_used = 0;
    int wcnt = 0;
    int lat = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_out       (pc_out),
        .branch_res   (branch_res),
        .new_pc       (new_pc),
        .br_taken_cnt (br_taken_cnt),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: walk the program from pc 0, k-th branch uses the k-th outcome.
    function automatic void buildExpected();
        logic [11:0] pc;
        logic [15:0] cnt;
        int k;
        exp_t e;
        pc = 12'd0;
        cnt = 16'd0;
        k = 0;
        sb.delete();
        for (int i = 0; i < 600; i++) begin
            e.pc = pc;
            e.instr = mem[pc];
            e.cnt = cnt;
            sb.push_back(e);
`ifdef FETCH_HALT_EN
            if (e.instr == 16'hFFFF) break;
`endif
            if (e.instr[1:0] == 2'd2) begin
                if (br_take[k]) begin
                    pc = br_tgt[k];
                    if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
                end else begin
                    pc = pc + 12'd1;
                end
                k++;
            end else begin
                pc = pc + 12'd1;
            end
        end
    endfunction

    // Memory with random latency, random ready, branch-stage outcomes and branch noise.
    task automatic applyStimulus();
        if (!rst_n) begin
            imem_valid  = 1'b0;
            wcnt        = 0;
            lat         = 0;
            br_used     = 0;
            branch_res  = 1'b0;
            new_pc      = '0;
            instr_ready = 1'b0;
            return;
        end
        if (imem_req) begin
            if (wcnt >= lat) begin
                imem_valid = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_valid = 1'b0;
                imem_rdata = 16'($urandom);
            end
            wcnt++;
        end else begin
            wcnt = 0;
            lat = strict ? 0 : int'($urandom_range(0, 3));
            imem_valid = ($urandom % 4) == 0;
            imem_rdata = 16'($urandom);
        end
        if (br_seen > br_used) begin
            branch_res = br_take[br_used];
            new_pc = br_tgt[br_used];
            br_used++;
        end else begin
            branch_res = 1'($urandom);
            new_pc = 12'($urandom);
        end
        instr_ready = strict ? 1'b1 : (($urandom % 3) != 0);
    endtask

    always @(posedge clk) begin
        #1;
        applyStimulus();
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hs_count  = 0;
            br_seen   = 0;
            gap_valid = 1'b0;
        end else if (instr_valid) begin
            checkOutput("req_low_in_issue", 32'(imem_req), 32'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_issue", 32'd1, 32'd0);
            end else begin
                checkOutput("instr_out", 32'(instr_out), 32'(sb[0].instr));
                checkOutput("pc_out", 32'(pc_out), 32'(sb[0].pc));
                checkOutput("pc_held", 32'(imem_addr), 32'(sb[0].pc));
                if (instr_ready) begin
                    checkOutput("br_taken_cnt", 32'(br_taken_cnt), 32'(sb[0].cnt));
                    if (strict && gap_valid)
                        checkOutput("issue_gap", 32'(cycle - last_cycle), last_br ? 32'd3 : 32'd2);
                    last_cycle = cycle;
                    last_br = (sb[0].instr[1:0] == 2'd2);
                    gap_valid = strict;
                    if (sb[0].instr[1:0] == 2'd2) br_seen++;
                    hs_count++;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic resetCheck();
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr_out", 32'(instr_out), 32'd0);
        checkOutput("rst_pc_out", 32'(pc_out), 32'd0);
        checkOutput("rst_br_taken_cnt", 32'(br_taken_cnt), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
    endtask

    task automatic waitHandshakes(input int target, input int limit);
        int n;
        n = 0;
        while (hs_count < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (hs_count < target) checkOutput("handshake_timeout", 32'(hs_count), 32'(target));
    endtask

    initial begin
        int n;
        logic bad;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i] == 16'hFFFF) mem[i] = 16'h1234;
        end
        for (int i = 0; i < 1024; i++) begin
            br_take[i] = 1'($urandom);
            br_tgt[i] = 12'($urandom);
        end
        for (int i = 0; i < 4; i++) mem[i] = {14'($urandom), 2'b01};
        mem[4]       = 16'h00A2;
        mem[12'h00A] = {14'($urandom), 2'b10};
        mem[12'hFFE] = {14'($urandom), 2'b00};
        mem[12'hFFF] = {14'($urandom), 2'b00};
        br_take[0] = 1'b1; br_tgt[0] = 12'h00A;
        br_take[1] = 1'b1; br_tgt[1] = 12'hFFE;
        br_take[2] = 1'b0;

        #2 rst_n = 1'b0;
        #1 resetCheck();
        buildExpected();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait, always-ready start: 0..4, taken to A, taken to FFE, wrap, not-taken at 4.
        waitHandshakes(14, 200);
        strict = 1'b0;
        waitHandshakes(300, 6000);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req && n < 50);
        checkOutput("fetch_before_reset", 32'(imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 resetCheck();
        buildExpected();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitHandshakes(100, 2000);

        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) mem[i] = {14'($urandom), 2'b01};
        mem[3] = 16'hFFFF;
        buildExpected();
        #1 resetCheck();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef FETCH_HALT_EN
        waitHandshakes(4, 200);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req || instr_valid) bad = 1'b1;
        end
        checkOutput("activity_after_halt", 32'(bad), 32'd0);
        checkOutput("halted", 32'(halted), 32'd1);
        checkOutput("halt_pc", 32'(imem_addr), 32'd4);
`else
        bad = 1'b0;
        waitHandshakes(5, 200);
        checkOutput("halted_tied", 32'(halted | bad), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
